psg_write_ctrl: RTL and testbench

PSG_WRITE_CTRL -- requirements
Module: psg_write_ctrl

---
 rtl/psg_write_ctrl.sv | 131 +++++++++++++
 tb/tb_psg_write_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_ctrl.sv
// Z80 I/O-port to PSG bridge: decodes writes to ports 0x40-0x7F, buffers bytes in a
// small FIFO and replays them to the PSG with a CE/WE handshake on psgReady.
module psg_write_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int WAIT_ENABLE   = 1,
  parameter int READY_TIMEOUT = 4
) (
  input  logic       clock,
  input  logic       nRESET,
  input  logic       nIORQ,
  input  logic       nWR,
  input  logic       CA7,
  input  logic       CA6,
  input  logic [7:0] CD,
  input  logic       psgReady,
  output logic [7:0] psgD,
  output logic       psgnCE,
  output logic       psgnWE,
  output logic       nWAIT,
  output logic [4:0] fifoLevel,
  output logic       overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(READY_TIMEOUT + 1);
  localparam bit WAIT_EN = (WAIT_ENABLE != 0);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_LOW, WAIT_HIGH} state_t;

  state_t             state_q, state_d;
  logic               strobe_q;
  logic               pend_q, pend_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]         level_q, level_d;
  logic               ovf_q;
  logic [7:0]         psgd_q, psgd_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;

  logic strobe, wr_event, full, pop, push, drop;

  assign strobe   = ~nIORQ & ~nWR & ~CA7 & CA6;
  assign wr_event = strobe & ~strobe_q;
  assign full     = (level_q == 5'(FIFO_DEPTH));
  assign pop      = (state_q == IDLE) && (level_q != 5'd0) && psgReady;
  assign push     = pend_q && (!full || pop);
  assign drop     = !WAIT_EN && pend_q && full && !pop;

  // A held byte that cannot enter the FIFO stalls the CPU until the push happens.
  assign nWAIT     = !(WAIT_EN && pend_q && !push);
  assign psgnCE    = !((state_q == ASSERT) || (state_q == WAIT_LOW));
  assign psgnWE    = psgnCE;
  assign psgD      = psgd_q;
  assign fifoLevel = level_q;
  assign overflow  = ovf_q;

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (push || drop) pend_d = 1'b0;
    if (wr_event) begin
      pend_d      = 1'b1;
      pend_data_d = CD;
    end
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    psgd_d  = psgd_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ASSERT;
          psgd_d  = mem_q[rd_ptr_q];
        end
      end
      ASSERT: begin
        state_d = WAIT_LOW;
        tmo_d   = '0;
      end
      WAIT_LOW: begin
        // Give up on a PSG that never acknowledges so the queue keeps draining.
        if (!psgReady || (tmo_q == CNT_W'(READY_TIMEOUT - 1))) state_d = WAIT_HIGH;
        else tmo_d = tmo_q + CNT_W'(1);
      end
      WAIT_HIGH: begin
        if (psgReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      strobe_q    <= 1'b1;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= 5'd0;
      ovf_q       <= 1'b0;
      psgd_q      <= 8'h00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= strobe;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      level_q     <= level_d;
      psgd_q      <= psgd_d;
      tmo_q       <= tmo_d;
      if (drop) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= pend_data_q;
  end

endmodule

// File: tb/tb_psg_write_ctrl.sv
// Bench for psg_write_ctrl: a stalling instance and a dropping instance share stimulus;
// bytes seen on each PSG strobe are matched against queues of expected bytes.
module tb_psg_write_ctrl;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       nRESET, nIORQ, nWR, CA7, CA6, psgReady;
  logic [7:0] CD;
  logic [7:0] psgD, psgD_0;
  logic       psgnCE, psgnWE, nWAIT, overflow;
  logic       psgnCE_0, psgnWE_0, nWAIT_0, overflow_0;
  logic [4:0] fifoLevel, fifoLevel_0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$], obs_q[$], exp0_q[$], obs0_q[$];
  logic       ce_prev = 1'b1, ce0_prev = 1'b1;

  logic [7:0] dec_addr [5] = '{8'h3F, 8'h80, 8'hBF, 8'h40, 8'h7E};
  logic [7:0] dec_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [4:0] dec_lvl  [5] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2};

  always #5 clock = ~clock;

  psg_write_ctrl dut (
    .clock(clock), .nRESET(nRESET), .nIORQ(nIORQ), .nWR(nWR), .CA7(CA7), .CA6(CA6),
    .CD(CD), .psgReady(psgReady), .psgD(psgD), .psgnCE(psgnCE), .psgnWE(psgnWE),
    .nWAIT(nWAIT), .fifoLevel(fifoLevel), .overflow(overflow)
  );

  psg_write_ctrl #(.WAIT_ENABLE(0)) dut0 (
    .clock(clock), .nRESET(nRESET), .nIORQ(nIORQ), .nWR(nWR), .CA7(CA7), .CA6(CA6),
    .CD(CD), .psgReady(psgReady), .psgD(psgD_0), .psgnCE(psgnCE_0), .psgnWE(psgnWE_0),
    .nWAIT(nWAIT_0), .fifoLevel(fifoLevel_0), .overflow(overflow_0)
  );

  // Capture the data byte at the start of every PSG strobe.
  always @(negedge clock) begin
    if (ce_prev && !psgnCE) obs_q.push_back(psgD);
    if (ce0_prev && !psgnCE_0) obs0_q.push_back(psgD_0);
    ce_prev  = psgnCE;
    ce0_prev = psgnCE_0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    nIORQ = 1'b1; nWR = 1'b1; CA7 = 1'b1; CA6 = 1'b1; CD = 8'h00;
  endtask

  task automatic bus_write_start(input logic [7:0] addr, input logic [7:0] data);
    nIORQ = 1'b0; nWR = 1'b0; CA7 = addr[7]; CA6 = addr[6]; CD = data;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus_write_start(addr, data);
    tick(); tick();
    bus_idle();
    tick();
  endtask

  task automatic apply_reset();
    bus_idle();
    nRESET = 1'b0;
    tick(); tick();
    exp_q.delete(); obs_q.delete(); exp0_q.delete(); obs0_q.delete();
    nRESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus_idle();
    psgReady = 1'b1;
    nRESET = 1'b0;
    #2;
    total_cnt++; if (psgD !== 8'h00)      $display("FAIL rst_psgD got=%0h exp=00", psgD); else pass_cnt++;
    total_cnt++; if (psgnCE !== 1'b1)     $display("FAIL rst_psgnCE got=%0b exp=1", psgnCE); else pass_cnt++;
    total_cnt++; if (psgnWE !== 1'b1)     $display("FAIL rst_psgnWE got=%0b exp=1", psgnWE); else pass_cnt++;
    total_cnt++; if (nWAIT !== 1'b1)      $display("FAIL rst_nWAIT got=%0b exp=1", nWAIT); else pass_cnt++;
    total_cnt++; if (fifoLevel !== 5'd0)  $display("FAIL rst_level got=%0d exp=0", fifoLevel); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0)   $display("FAIL rst_overflow got=%0b exp=0", overflow); else pass_cnt++;
    tick();
    nRESET = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic [7:0] e, o;
    apply_reset();
    psgReady = 1'b1;
    bus_write_start(8'h7F, 8'h9F);
    exp_q.push_back(8'h9F);
    tick();
    total_cnt++; if (fifoLevel !== 5'd0) $display("FAIL single_lvl0 got=%0d exp=0", fifoLevel); else pass_cnt++;
    total_cnt++; if (nWAIT !== 1'b1)     $display("FAIL single_nwait got=%0b exp=1", nWAIT); else pass_cnt++;
    tick();
    total_cnt++; if (fifoLevel !== 5'd1) $display("FAIL single_lvl1 got=%0d exp=1", fifoLevel); else pass_cnt++;
    bus_idle();
    tick();
    total_cnt++; if (fifoLevel !== 5'd0) $display("FAIL single_lvl2 got=%0d exp=0", fifoLevel); else pass_cnt++;
    total_cnt++; if (psgnCE !== 1'b0 || psgnWE !== 1'b0)
      $display("FAIL single_strobe got=%0b%0b exp=00", psgnCE, psgnWE); else pass_cnt++;
    total_cnt++; if (psgD !== 8'h9F)     $display("FAIL single_psgD got=%0h exp=9f", psgD); else pass_cnt++;
    psgReady = 1'b0;
    tick(); tick();
    total_cnt++; if (psgnCE !== 1'b1)    $display("FAIL single_release got=%0b exp=1", psgnCE); else pass_cnt++;
    psgReady = 1'b1;
    repeat (20) tick();
    total_cnt++; if (obs_q.size() != exp_q.size())
      $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++; if (o !== e) $display("FAIL single_data got=%0h exp=%0h", o, e); else pass_cnt++;
    end
  endtask

  task automatic test_decode();
    logic [7:0] e, o;
    apply_reset();
    psgReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dec_lvl[i] != 5'd0) exp_q.push_back(dec_data[i]);
      wr(dec_addr[i], dec_data[i]);
      total_cnt++; if (fifoLevel !== dec_lvl[i])
        $display("FAIL decode_lvl addr=%0h got=%0d exp=%0d", dec_addr[i], fifoLevel, dec_lvl[i]); else pass_cnt++;
    end
    psgReady = 1'b1;
    repeat (40) tick();
    total_cnt++; if (obs_q.size() != exp_q.size())
      $display("FAIL decode_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++; if (o !== e) $display("FAIL decode_data got=%0h exp=%0h", o, e); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    apply_reset();
    psgReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      exp0_q.push_back(8'h80 + 8'(i));
      wr(8'h40, 8'h80 + 8'(i));
    end
    total_cnt++; if (fifoLevel !== 5'd4) $display("FAIL burst_full got=%0d exp=4", fifoLevel); else pass_cnt++;
    bus_write_start(8'h40, 8'h84);
    exp_q.push_back(8'h84);
    tick();
    total_cnt++; if (nWAIT !== 1'b0)   $display("FAIL burst_nwait got=%0b exp=0", nWAIT); else pass_cnt++;
    total_cnt++; if (nWAIT_0 !== 1'b1) $display("FAIL drop_nwait got=%0b exp=1", nWAIT_0); else pass_cnt++;
    tick();
    total_cnt++; if (overflow_0 !== 1'b1) $display("FAIL drop_overflow got=%0b exp=1", overflow_0); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0)   $display("FAIL burst_overflow got=%0b exp=0", overflow); else pass_cnt++;
    bus_idle();
    tick();
    total_cnt++; if (nWAIT !== 1'b0) $display("FAIL burst_hold got=%0b exp=0", nWAIT); else pass_cnt++;
    psgReady = 1'b1;
    tick();
    total_cnt++; if (nWAIT !== 1'b1)       $display("FAIL burst_release got=%0b exp=1", nWAIT); else pass_cnt++;
    total_cnt++; if (fifoLevel !== 5'd4)   $display("FAIL burst_pushpop got=%0d exp=4", fifoLevel); else pass_cnt++;
    total_cnt++; if (fifoLevel_0 !== 5'd3) $display("FAIL drop_level got=%0d exp=3", fifoLevel_0); else pass_cnt++;
    repeat (80) tick();
    total_cnt++; if (overflow_0 !== 1'b1) $display("FAIL drop_sticky got=%0b exp=1", overflow_0); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size())
      $display("FAIL burst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++; if (o !== e) $display("FAIL burst_data got=%0h exp=%0h", o, e); else pass_cnt++;
    end
    total_cnt++; if (obs0_q.size() != exp0_q.size())
      $display("FAIL drop_count got=%0d exp=%0d", obs0_q.size(), exp0_q.size()); else pass_cnt++;
    while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
      e = exp0_q.pop_front(); o = obs0_q.pop_front();
      total_cnt++; if (o !== e) $display("FAIL drop_data got=%0h exp=%0h", o, e); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e, o;
    int low_cnt, we_cnt;
    apply_reset();
    psgReady = 1'b1;
    exp_q.push_back(8'h55);
    wr(8'h40, 8'h55);
    low_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (psgnCE == 1'b0) begin
        low_cnt++;
        if (psgnWE == 1'b0) we_cnt++;
      end else if (low_cnt > 0) begin
        break;
      end
      tick();
    end
    // One ASSERT cycle plus the full WAIT_LOW timeout.
    total_cnt++; if (low_cnt != 1 + TO) $display("FAIL timeout_ce got=%0d exp=%0d", low_cnt, 1 + TO); else pass_cnt++;
    total_cnt++; if (we_cnt != 1 + TO)  $display("FAIL timeout_we got=%0d exp=%0d", we_cnt, 1 + TO); else pass_cnt++;
    exp_q.push_back(8'hA6);
    wr(8'h40, 8'hA6);
    repeat (30) tick();
    total_cnt++; if (obs_q.size() != exp_q.size())
      $display("FAIL timeout_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total_cnt++; if (o !== e) $display("FAIL timeout_data got=%0h exp=%0h", o, e); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    psgReady = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'h40, 8'hC0 + 8'(i));
    psgReady = 1'b1;
    tick(); tick();
    total_cnt++; if (fifoLevel !== 5'd3) $display("FAIL midop_level got=%0d exp=3", fifoLevel); else pass_cnt++;
    total_cnt++; if (psgnCE !== 1'b0)    $display("FAIL midop_active got=%0b exp=0", psgnCE); else pass_cnt++;
    nRESET = 1'b0;
    #1;
    obs_q.delete();
    total_cnt++; if (psgnCE !== 1'b1 || psgnWE !== 1'b1)
      $display("FAIL midop_strobe got=%0b%0b exp=11", psgnCE, psgnWE); else pass_cnt++;
    total_cnt++; if (fifoLevel !== 5'd0) $display("FAIL midop_flush got=%0d exp=0", fifoLevel); else pass_cnt++;
    total_cnt++; if (psgD !== 8'h00)     $display("FAIL midop_psgD got=%0h exp=00", psgD); else pass_cnt++;
    bus_write_start(8'h40, 8'hEE);
    tick();
    nRESET = 1'b1;
    tick(); tick();
    bus_idle();
    repeat (40) tick();
    total_cnt++; if (fifoLevel !== 5'd0) $display("FAIL midop_noevent got=%0d exp=0", fifoLevel); else pass_cnt++;
    total_cnt++; if (obs_q.size() != 0)  $display("FAIL midop_nostrobe got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  initial begin
    bus_idle();
    psgReady = 1'b1;
    nRESET = 1'b0;
    test_reset();
    test_single_write();
    test_decode();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
